rom_list_scanner: RTL and testbench

Sequencer that owns the read port of the 512x8 lookup ROM and walks a sentinel-terminated list stored in it. On `start`, it issues back-to-back reads from a base address until it reads the terminator byte or reaches the last ROM address, and accumulates the entry count, sum and maximum of the non-terminator bytes. It sits between the control logic and the ROM and drives the ROM's address and read-enable directly. It runs on the same clock as the ROM and relies on the ROM's one-edge registered read latency.

---
 rtl/rom_list_scanner.sv | 108 ++++++++++
 tb/tb_rom_list_scanner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rom_list_scanner.sv
// rom_list_scanner: walks a sentinel-terminated list in a 512x8 registered ROM,
// reporting entry count, sum and maximum of the non-terminator bytes.
module rom_list_scanner #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8,
   parameter logic [DATA_W-1:0] SENTINEL = 8'hFF
) (
   input  logic              control,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rd_en,
   input  logic [DATA_W-1:0] rom_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic [16:0]       sum,
   output logic [DATA_W-1:0] max,
   output logic              no_term
);
   localparam logic [ADDR_W-1:0] LAST = '1;
   typedef enum logic [1:0] {IDLE, PRIME, SCAN} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] data_addr, data_addr_n, rom_addr_n;
   logic              rd_en_n, busy_n, done_n, no_term_n;
   logic [ADDR_W:0]   count_n;
   logic [16:0]       sum_n;
   logic [DATA_W-1:0] max_n;
   always_comb begin
      state_n = state;
      rom_addr_n = rom_addr;
      rd_en_n = rom_rd_en;
      busy_n = busy;
      done_n = 1'b0;
      count_n = count;
      sum_n = sum;
      max_n = max;
      no_term_n = no_term;
      data_addr_n = data_addr;
      case (state)
         IDLE: if (start) begin
            rom_addr_n = base;
            data_addr_n = base;
            rd_en_n = 1'b1;
            busy_n = 1'b1;
            count_n = '0;
            sum_n = '0;
            max_n = '0;
            no_term_n = 1'b0;
            state_n = PRIME;
         end
         PRIME: begin
            state_n = SCAN;
            if (rom_addr != LAST) rom_addr_n = rom_addr + 1'b1;
            else rd_en_n = 1'b0;
         end
         SCAN: if (rom_data == SENTINEL) begin
            rd_en_n = 1'b0;
            done_n = 1'b1;
            busy_n = 1'b0;
            state_n = IDLE;
         end else begin
            count_n = count + 1'b1;
            sum_n = sum + 17'(rom_data);
            max_n = (rom_data > max) ? rom_data : max;
            // the last ROM word was consumed without a terminator
            if (data_addr == LAST) begin
               no_term_n = 1'b1;
               done_n = 1'b1;
               busy_n = 1'b0;
               rd_en_n = 1'b0;
               state_n = IDLE;
            end else begin
               data_addr_n = data_addr + 1'b1;
               if (rom_addr != LAST) rom_addr_n = rom_addr + 1'b1;
               else rd_en_n = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge control) begin
      if (reset) begin
         state <= IDLE;
         rom_addr <= '0;
         rom_rd_en <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         count <= '0;
         sum <= '0;
         max <= '0;
         no_term <= 1'b0;
         data_addr <= '0;
      end else begin
         state <= state_n;
         rom_addr <= rom_addr_n;
         rom_rd_en <= rd_en_n;
         busy <= busy_n;
         done <= done_n;
         count <= count_n;
         sum <= sum_n;
         max <= max_n;
         no_term <= no_term_n;
         data_addr <= data_addr_n;
      end
   end
endmodule

// File: tb/tb_rom_list_scanner.sv
// tb_rom_list_scanner: scoreboard bench with a registered 512x8 ROM model;
// expected results and done-cycle are queued at start, popped on done.
module tb_rom_list_scanner;
   logic       control = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [8:0] base = '0;
   logic [8:0] rom_addr;
   logic       rom_rd_en;
   logic [7:0] rom_data = '0;
   logic       busy, done, no_term;
   logic [9:0] count;
   logic [16:0] sum;
   logic [7:0] max;
   logic [7:0] mem [512];

   typedef struct {
      int cnt;
      int sm;
      int mx;
      int nt;
      int dcyc;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_total = 0;
   int rd_base = 0;
   int e0 = 0;

   rom_list_scanner dut (
      .control(control), .reset(reset), .start(start), .base(base),
      .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
      .busy(busy), .done(done), .count(count), .sum(sum), .max(max),
      .no_term(no_term)
   );

   always #5 control = ~control;
   always @(posedge control) cyc <= cyc + 1;
   always @(posedge control) if (rom_rd_en) rom_data <= mem[rom_addr];
   always @(negedge control) if (rom_rd_en) rd_total <= rd_total + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge control) begin
      if (done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("done_cycle", cyc, e.dcyc);
            chk("count", count, e.cnt);
            chk("sum", sum, e.sm);
            chk("max", max, e.mx);
            chk("no_term", no_term, e.nt);
         end
      end
   end

   task automatic go(input int b, input int cnt, input int sm, input int mx, input int nt, input int off);
      @(negedge control);
      start = 1'b1;
      base = 9'(b);
      rd_base = rd_total;
      e0 = cyc + 1;
      q.push_back('{cnt, sm, mx, nt, e0 + off});
      @(negedge control);
      start = 1'b0;
   endtask

   task automatic wait_q();
      int t = 0;
      while (q.size() != 0 && t < 2000) begin
         @(negedge control);
         t++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", t);
         q.delete();
      end
      repeat (2) @(negedge control);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_rom_addr"}, rom_addr, 0);
      chk({tag, "_rom_rd_en"}, rom_rd_en, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_sum"}, sum, 0);
      chk({tag, "_max"}, max, 0);
      chk({tag, "_no_term"}, no_term, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "global timeout");
   end

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'd0;
      mem[0] = 8'd27; mem[1] = 8'd5; mem[2] = 8'd33; mem[3] = 8'd3; mem[4] = 8'hFF;
      repeat (3) @(negedge control);
      chk_reset_state("por");
      reset = 1'b0;
      // basic list, with extra start pulses at edges 3 and 6, then held into edge 7
      @(negedge control);
      start = 1'b1;
      base = 9'd0;
      e0 = cyc + 1;
      q.push_back('{4, 68, 33, 0, e0 + 6});
      @(negedge control);
      start = 1'b0;
      repeat (2) @(negedge control);
      start = 1'b1;
      @(negedge control);
      start = 1'b0;
      repeat (2) @(negedge control);
      start = 1'b1;
      q.push_back('{4, 68, 33, 0, e0 + 13});
      repeat (2) @(negedge control);
      start = 1'b0;
      wait_q();
      // base points directly at the terminator
      go(4, 0, 0, 0, 0, 2);
      wait_q();
      chk("rd_en_cycles_empty", rd_total - rd_base, 2);
      // tail of ROM without terminator
      mem[509] = 8'd10; mem[510] = 8'd200; mem[511] = 8'd7;
      go(509, 3, 217, 200, 1, 4);
      wait_q();
      chk("rom_addr_tail", rom_addr, 511);
      // whole ROM full of 0xFE
      for (int i = 0; i < 512; i++) mem[i] = 8'hFE;
      go(0, 512, 130048, 254, 1, 513);
      wait_q();
      chk("rd_en_cycles_full", rd_total - rd_base, 512);
      // reset in the middle of a scan
      mem[0] = 8'd27; mem[1] = 8'd5; mem[2] = 8'd33; mem[3] = 8'd3; mem[4] = 8'hFF;
      @(negedge control);
      start = 1'b1;
      base = 9'd0;
      @(negedge control);
      start = 1'b0;
      @(negedge control);
      chk("mid_scan_busy", busy, 1);
      reset = 1'b1;
      @(negedge control);
      chk_reset_state("mid");
      reset = 1'b0;
      repeat (10) @(negedge control);
      chk("post_reset_busy", busy, 0);
      go(0, 4, 68, 33, 0, 6);
      wait_q();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
